// File: rtl/spike_vote_decoder.sv
// rtl/spike_vote_decoder.sv - per-class spike counting over a pulse window, then sequential argmax vote
module spike_vote_decoder #(
    parameter int N_OUT  = 10,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 100
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pulse,
    input  logic [N_OUT-1:0] spk_in,
    output logic             busy,
    output logic             valid,
    output logic [3:0]       class_out,
    output logic [CNT_W-1:0] max_count,
    output logic             tie,
    output logic             no_spike
);

    localparam int               IDX_W        = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IDX_W-1:0] LP_J_LAST    = IDX_W'(N_OUT - 1);
    localparam logic [15:0]      LP_STEP_LAST = 16'(WINDOW - 1);
    localparam logic [CNT_W-1:0] LP_CNT_MAX   = '1;

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_SCAN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt [N_OUT];
    logic [15:0]      r_step;
    logic [IDX_W-1:0] r_j;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_best;
    logic             r_tie;
    logic [3:0]       r_class_out;
    logic [CNT_W-1:0] r_max_count;
    logic             r_tie_out;
    logic             r_no_spike;

    logic             w_last_pulse;
    logic             w_last_j;
    logic [CNT_W-1:0] w_cnt_j;
    logic [CNT_W-1:0] w_best_next;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_tie_next;

    assign w_last_pulse = (r_step == LP_STEP_LAST);
    assign w_last_j     = (r_j == LP_J_LAST);
    assign w_cnt_j      = r_cnt[r_j];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_COUNT;
            S_COUNT: if (pulse && w_last_pulse) w_state_next = S_SCAN;
            S_SCAN:  if (w_last_j) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Running argmax: strict '>' keeps the lowest index on equal counts.
    always_comb begin
        w_best_next = r_best;
        w_idx_next  = r_idx;
        w_tie_next  = r_tie;
        if (r_j == '0) begin
            w_best_next = w_cnt_j;
            w_idx_next  = '0;
            w_tie_next  = 1'b0;
        end else if (w_cnt_j > r_best) begin
            w_best_next = w_cnt_j;
            w_idx_next  = r_j;
            w_tie_next  = 1'b0;
        end else if (w_cnt_j == r_best) begin
            w_tie_next  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
            r_step      <= '0;
            r_j         <= '0;
            r_idx       <= '0;
            r_best      <= '0;
            r_tie       <= 1'b0;
            r_class_out <= '0;
            r_max_count <= '0;
            r_tie_out   <= 1'b0;
            r_no_spike  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N_OUT; i++) r_cnt[i] <= '0;
                        r_step <= '0;
                    end
                end
                S_COUNT: begin
                    if (pulse) begin
                        for (int i = 0; i < N_OUT; i++) begin
                            if (spk_in[i] && (r_cnt[i] != LP_CNT_MAX)) begin
                                r_cnt[i] <= r_cnt[i] + 1'b1;
                            end
                        end
                        r_step <= r_step + 16'd1;
                        r_j    <= '0;
                    end
                end
                S_SCAN: begin
                    r_best <= w_best_next;
                    r_idx  <= w_idx_next;
                    r_tie  <= w_tie_next;
                    r_j    <= r_j + 1'b1;
                    // Results land on the edge into DONE so they coincide with valid.
                    if (w_last_j) begin
                        r_class_out <= 4'(w_idx_next);
                        r_max_count <= w_best_next;
                        r_tie_out   <= w_tie_next;
                        r_no_spike  <= (w_best_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == S_COUNT) || (r_state == S_SCAN);
    assign valid     = (r_state == S_DONE);
    assign class_out = r_class_out;
    assign max_count = r_max_count;
    assign tie       = r_tie_out;
    assign no_spike  = r_no_spike;

endmodule

// File: tb/tb_spike_vote_decoder.sv
// tb/tb_spike_vote_decoder.sv - vector table, corner sequences and randomized model check for spike_vote_decoder
module tb_spike_vote_decoder;

    localparam int N_OUT = 10;
    localparam int WIN   = 4;

    logic             clk = 1'b0;
    logic             reset, start, pulse;
    logic [N_OUT-1:0] spk_in;
    logic             busy, valid, tie, no_spike;
    logic [3:0]       class_out;
    logic [7:0]       max_count;
    logic             s_busy, s_valid, s_tie, s_no_spike;
    logic [3:0]       s_class_out;
    logic [1:0]       s_max_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_vote_decoder #(.N_OUT(N_OUT), .CNT_W(8), .WINDOW(WIN)) u_dut (
        .clk(clk), .reset(reset), .start(start), .pulse(pulse), .spk_in(spk_in),
        .busy(busy), .valid(valid), .class_out(class_out), .max_count(max_count),
        .tie(tie), .no_spike(no_spike)
    );

    spike_vote_decoder #(.N_OUT(N_OUT), .CNT_W(2), .WINDOW(WIN)) u_sat (
        .clk(clk), .reset(reset), .start(start), .pulse(pulse), .spk_in(spk_in),
        .busy(s_busy), .valid(s_valid), .class_out(s_class_out), .max_count(s_max_count),
        .tie(s_tie), .no_spike(s_no_spike)
    );

    typedef struct {
        logic [39:0] pats;
        int ec, em, et, en;
        int sc, sm, st, sn;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] pk(input logic [9:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic void model(input logic [39:0] p, input int cmax,
                                  output int cls, output int mx, output int t, output int ns);
        int c [N_OUT];
        int nt;
        mx = 0;
        for (int i = 0; i < N_OUT; i++) begin
            c[i] = 0;
            for (int k = 0; k < WIN; k++) c[i] += int'(p[k*N_OUT + i]);
            if (c[i] > cmax) c[i] = cmax;
            if (c[i] > mx) mx = c[i];
        end
        cls = -1;
        nt  = 0;
        for (int i = 0; i < N_OUT; i++) begin
            if (c[i] == mx) begin
                if (cls < 0) cls = i;
                nt++;
            end
        end
        t  = (nt > 1) ? 1 : 0;
        ns = (mx == 0) ? 1 : 0;
    endfunction

    // gated=1 adds ignored traffic: a pulse with start, plus start and unstrobed spikes between pulses.
    task automatic run_inf(input string tag, input logic [39:0] p, input bit gated, input vec_t e);
        int  n;
        bit  seen;
        start  = 1'b1;
        pulse  = gated;
        spk_in = gated ? '1 : '0;
        tick();
        chk({tag, ":busy_after_start"}, busy, 1);
        start = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            if (gated) begin
                start  = 1'b1;
                pulse  = 1'b0;
                spk_in = '1;
                tick();
                start  = 1'b0;
            end
            pulse  = 1'b1;
            spk_in = p[k*N_OUT +: N_OUT];
            tick();
        end
        pulse  = 1'b0;
        spk_in = '0;
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 40) begin
            if (valid) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk({tag, ":valid_seen"}, seen, 1);
        if (seen) begin
            // valid is observed just after edge n; the consumer samples it on edge n+1
            chk({tag, ":latency"}, n + 1, N_OUT + 1);
            chk({tag, ":busy_in_done"}, busy, 0);
            chk({tag, ":class"}, class_out, e.ec);
            chk({tag, ":max"}, max_count, e.em);
            chk({tag, ":tie"}, tie, e.et);
            chk({tag, ":no_spike"}, no_spike, e.en);
            chk({tag, ":s_valid"}, s_valid, 1);
            chk({tag, ":s_class"}, s_class_out, e.sc);
            chk({tag, ":s_max"}, s_max_count, e.sm);
            chk({tag, ":s_tie"}, s_tie, e.st);
            chk({tag, ":s_no_spike"}, s_no_spike, e.sn);
            tick();
            chk({tag, ":valid_one_cycle"}, valid, 0);
            chk({tag, ":class_hold"}, class_out, e.ec);
        end
    endtask

    initial begin
        int   vcount;
        vec_t rv;

        vecs[0] = '{pk(10'h009, 10'h009, 10'h008, 10'h008), 3, 4, 0, 0, 3, 3, 0, 0};
        vecs[1] = '{pk(10'h084, 10'h084, 10'h084, 10'h084), 2, 4, 1, 0, 2, 3, 1, 0};
        vecs[2] = '{pk(10'h000, 10'h000, 10'h000, 10'h000), 0, 0, 1, 1, 0, 0, 1, 1};
        vecs[3] = '{pk(10'h022, 10'h022, 10'h022, 10'h020), 5, 4, 0, 0, 1, 3, 1, 0};
        vecs[4] = '{pk(10'h200, 10'h201, 10'h000, 10'h000), 9, 2, 0, 0, 9, 2, 0, 0};

        reset  = 1'b1;
        start  = 1'b0;
        pulse  = 1'b0;
        spk_in = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst:busy", busy, 0);
        chk("rst:valid", valid, 0);
        chk("rst:class", class_out, 0);
        chk("rst:max", max_count, 0);
        chk("rst:tie", tie, 0);
        chk("rst:no_spike", no_spike, 0);
        chk("rst:s_valid", s_valid, 0);
        chk("rst:s_busy", s_busy, 0);

        // Pulses while IDLE must not start or affect anything.
        pulse  = 1'b1;
        spk_in = '1;
        tick();
        tick();
        pulse  = 1'b0;
        chk("idle_pulse:busy", busy, 0);

        for (int v = 0; v < 5; v++) begin
            run_inf($sformatf("vec%0d", v), vecs[v].pats, 1'b0, vecs[v]);
        end

        run_inf("gated", vecs[0].pats, 1'b1, vecs[0]);

        // Abort three cycles into SCAN; previous results (class 3, max 4) must clear.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < WIN; k++) begin
            pulse  = 1'b1;
            spk_in = vecs[4].pats[k*N_OUT +: N_OUT];
            tick();
        end
        pulse  = 1'b0;
        spk_in = '0;
        tick();
        tick();
        tick();
        chk("abort:busy_in_scan", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort:busy", busy, 0);
        chk("abort:valid", valid, 0);
        chk("abort:class", class_out, 0);
        chk("abort:max", max_count, 0);
        chk("abort:tie", tie, 0);
        chk("abort:no_spike", no_spike, 0);
        vcount = 0;
        for (int c = 0; c < 15; c++) begin
            if (valid || s_valid) vcount++;
            tick();
        end
        chk("abort:no_valid", vcount, 0);
        run_inf("after_abort", vecs[0].pats, 1'b0, vecs[0]);

        for (int r = 0; r < 25; r++) begin
            for (int k = 0; k < WIN; k++) begin
                rv.pats[k*N_OUT +: N_OUT] = N_OUT'($urandom_range(0, 1023) & $urandom_range(0, 1023));
            end
            model(rv.pats, 255, rv.ec, rv.em, rv.et, rv.en);
            model(rv.pats, 3, rv.sc, rv.sm, rv.st, rv.sn);
            run_inf($sformatf("rand%0d", r), rv.pats, 1'($urandom_range(0, 1)), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
